shift_seq_ctrl: RTL

Sequencing controller for the 32-bit left/right shifter array. Accepts a start request with operand, direction, mode and amount, then drives the one-hot per-bit select lines (L_SHIFT / R_SHIFT / NO_SHIFT) one single-bit step per cycle until the requested amount is reached. It holds the working register that the bit cells feed back into, and reports completion with a one-cycle DONE pulse. It sits between the instruction decode/issue logic and the shifter datapath.

---
 rtl/shifter_pkg.sv | 33 +++
 rtl/shift_step.sv | 39 +++
 rtl/shift_seq_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared types and defaults for the shifter sequencing controller and its
// single-step next-value generator.
package shifter_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_AW    = $clog2(DEFAULT_WIDTH);

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LOAD  = 2'b01,
      SHIFT = 2'b10,
      FIN   = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      LOGICAL = 2'b00,
      ARITH   = 2'b01,
      ROTATE  = 2'b10
   } mode_e;

   // The reserved encoding 2'b11 folds onto logical so nothing downstream sees it
   function automatic mode_e decode_mode(logic [1:0] raw);
      case (raw)
         2'b01:   return ARITH;
         2'b10:   return ROTATE;
         default: return LOGICAL;
      endcase
   endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit step of the shifter array: per-bit select muxing
// plus the edge fill bit that depends on direction and mode.
module shift_step
   import shifter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] data,
   input  logic             dir,
   input  mode_e            mode,
   input  logic             l_shift,
   input  logic             r_shift,
   input  logic             no_shift,
   output logic [WIDTH-1:0] next_data
);

   logic fill;

   // Rotate recirculates the bit falling off the far end; arithmetic only
   // replicates the sign bit when moving right
   always_comb begin
      fill = 1'b0;
      if (mode == ROTATE) begin
         fill = (dir == DIR_RIGHT) ? data[0] : data[WIDTH-1];
      end else if (mode == ARITH && dir == DIR_RIGHT) begin
         fill = data[WIDTH-1];
      end
   end

   always_comb begin
      next_data = data;
      case ({l_shift, r_shift, no_shift})
         3'b100:  next_data = {data[WIDTH-2:0], fill};
         3'b010:  next_data = {fill, data[WIDTH-1:1]};
         default: next_data = data;
      endcase
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencing controller for the shifter array: latches a request, loads the
// working register, then steps it one bit per cycle and pulses DONE.
module shift_seq_ctrl
   import shifter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int AW    = DEFAULT_AW
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             DIR,
   input  logic [1:0]       MODE,
   input  logic [AW-1:0]    AMT,
   input  logic [WIDTH-1:0] DATA_IN,
   output logic             L_SHIFT,
   output logic             R_SHIFT,
   output logic             NO_SHIFT,
   output logic [WIDTH-1:0] DATA_OUT,
   output logic             BUSY,
   output logic             DONE
);

   state_e           state;
   state_e           state_next;
   logic             dir_q;
   mode_e            mode_q;
   logic [AW-1:0]    amt_q;
   logic [AW-1:0]    count;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] step_next;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A zero amount skips SHIFT entirely; otherwise leave on the last step
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (START) state_next = LOAD;
         LOAD:    state_next = (amt_q == '0) ? FIN : SHIFT;
         SHIFT:   if (count == AW'(1)) state_next = FIN;
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      L_SHIFT  = 1'b0;
      R_SHIFT  = 1'b0;
      NO_SHIFT = 1'b1;
      BUSY     = (state != IDLE);
      DONE     = (state == FIN);
      if (state == SHIFT) begin
         NO_SHIFT = 1'b0;
         if (dir_q == DIR_RIGHT) begin
            R_SHIFT = 1'b1;
         end else begin
            L_SHIFT = 1'b1;
         end
      end
   end

   // Request fields are captured only in IDLE, so START while busy is dropped
   always_ff @(posedge CLK) begin
      if (RST) begin
         dir_q    <= DIR_LEFT;
         mode_q   <= LOGICAL;
         amt_q    <= '0;
         data_q   <= '0;
         count    <= '0;
         DATA_OUT <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  dir_q  <= DIR;
                  mode_q <= decode_mode(MODE);
                  amt_q  <= AMT;
                  data_q <= DATA_IN;
               end
            end
            LOAD: begin
               DATA_OUT <= data_q;
               count    <= amt_q;
            end
            SHIFT: begin
               DATA_OUT <= step_next;
               count    <= count - AW'(1);
            end
            default: ;
         endcase
      end
   end

   shift_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .data      (DATA_OUT),
      .dir       (dir_q),
      .mode      (mode_q),
      .l_shift   (L_SHIFT),
      .r_shift   (R_SHIFT),
      .no_shift  (NO_SHIFT),
      .next_data (step_next)
   );

endmodule
